// File: rtl/decode_compute1_stage1_pkg.sv
// Shared BPF encodings and the decoded control bundle for pipeline stage 1.
package decode_compute1_stage1_pkg;

  typedef enum logic [2:0] {
    CLS_LD, CLS_LDX, CLS_ST, CLS_STX, CLS_ALU, CLS_JMP, CLS_RET, CLS_MISC
  } bpf_class_e;

  typedef enum logic [1:0] {SZ_W, SZ_H, SZ_B, SZ_DW} bpf_size_e;

  typedef enum logic [2:0] {
    MODE_IMM, MODE_ABS, MODE_IND, MODE_MEM, MODE_LEN, MODE_MSH, MODE_RSV6, MODE_RSV7
  } bpf_mode_e;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_NEG = 4'h8;
  localparam logic [3:0] ALU_XOR = 4'hA;
  localparam logic [3:0] JMP_JA   = 4'h0;
  localparam logic [3:0] JMP_JSET = 4'h4;

  typedef enum logic [2:0] {
    A_SEL_IMM, A_SEL_PKT, A_SEL_ALU, A_SEL_X, A_SEL_MEM, A_SEL_LEN
  } a_sel_e;

  typedef enum logic [1:0] {X_SEL_IMM, X_SEL_PKT, X_SEL_A, X_SEL_MEM} x_sel_e;

  typedef enum logic [1:0] {ST_RUN, ST_JWAIT, ST_HALT} state_e;

  typedef struct packed {
    logic [3:0] alu_sel;
    logic [2:0] jmp_type;
    logic       pc_en;
    logic       pkt_rd;
    logic [1:0] xfer_sz;
    logic       rf_sel;
    logic       rf_wr;
    a_sel_e     a_sel;
    logic       a_en;
    x_sel_e     x_sel;
    logic       x_en;
    logic       ret_valid;
    logic       ret_sel;
  } ctrl_t;

endpackage

// File: rtl/decode_compute1_stage1_bpf_decode.sv
// Combinational BPF opcode decoder: control bundle, register read set and class flags.
module bpf_decode
  import decode_compute1_stage1_pkg::*;
(
  input  logic [15:0] opcode,
  output ctrl_t       ctrl,
  output logic        reads_a,
  output logic        reads_x,
  output logic        is_jmp,
  output logic        is_ret,
  output logic        illegal
);

  bpf_class_e cls;
  bpf_size_e  size;
  bpf_mode_e  mode;
  logic [3:0] op;
  logic       src;

  always_comb begin
    cls     = bpf_class_e'(opcode[2:0]);
    size    = bpf_size_e'(opcode[4:3]);
    mode    = bpf_mode_e'(opcode[7:5]);
    op      = opcode[7:4];
    src     = opcode[3];
    ctrl    = '0;
    reads_a = 1'b0;
    reads_x = 1'b0;
    is_jmp  = 1'b0;
    is_ret  = 1'b0;
    illegal = 1'b1;
    // Only the low opcode byte is defined; anything above it is undefined.
    if (opcode[15:8] == '0) begin
      case (cls)
        CLS_LD: begin
          case (mode)
            MODE_ABS, MODE_IND: if (size != SZ_DW) begin
              illegal      = 1'b0;
              ctrl.a_en    = 1'b1;
              ctrl.a_sel   = A_SEL_PKT;
              ctrl.pkt_rd  = 1'b1;
              ctrl.xfer_sz = size;
              reads_x      = (mode == MODE_IND);
            end
            MODE_IMM: if (size == SZ_W) begin
              illegal = 1'b0; ctrl.a_en = 1'b1; ctrl.a_sel = A_SEL_IMM;
            end
            MODE_MEM: if (size == SZ_W) begin
              illegal = 1'b0; ctrl.a_en = 1'b1; ctrl.a_sel = A_SEL_MEM;
            end
            MODE_LEN: if (size == SZ_W) begin
              illegal = 1'b0; ctrl.a_en = 1'b1; ctrl.a_sel = A_SEL_LEN;
            end
            default: ;
          endcase
        end
        CLS_LDX: begin
          if (mode == MODE_IMM && size == SZ_W) begin
            illegal = 1'b0; ctrl.x_en = 1'b1; ctrl.x_sel = X_SEL_IMM;
          end else if (mode == MODE_MEM && size == SZ_W) begin
            illegal = 1'b0; ctrl.x_en = 1'b1; ctrl.x_sel = X_SEL_MEM;
          end else if (mode == MODE_MSH && size == SZ_B) begin
            illegal      = 1'b0;
            ctrl.x_en    = 1'b1;
            ctrl.x_sel   = X_SEL_PKT;
            ctrl.pkt_rd  = 1'b1;
            ctrl.xfer_sz = SZ_B;
          end
        end
        CLS_ST, CLS_STX: if (opcode[7:3] == '0) begin
          illegal     = 1'b0;
          ctrl.rf_sel = 1'b1;
          ctrl.rf_wr  = 1'b1;
          reads_a     = (cls == CLS_ST);
          reads_x     = (cls == CLS_STX);
        end
        CLS_ALU: if (op <= ALU_XOR && !(op == ALU_NEG && src)) begin
          illegal      = 1'b0;
          ctrl.alu_sel = op;
          ctrl.a_sel   = A_SEL_ALU;
          ctrl.a_en    = 1'b1;
          reads_a      = 1'b1;
          reads_x      = src;
        end
        CLS_JMP: if (op <= JMP_JSET && !(op == JMP_JA && src)) begin
          illegal       = 1'b0;
          is_jmp        = 1'b1;
          ctrl.pc_en    = 1'b1;
          ctrl.jmp_type = op[2:0];
          reads_a       = 1'b1;
          reads_x       = src;
        end
        CLS_RET: if (opcode[7:3] == 5'b00000 || opcode[7:3] == 5'b00010) begin
          illegal        = 1'b0;
          is_ret         = 1'b1;
          ctrl.ret_valid = 1'b1;
          ctrl.ret_sel   = opcode[4];
          reads_a        = opcode[4];
        end
        CLS_MISC: begin
          if (opcode[7:3] == 5'b00000) begin
            illegal = 1'b0; ctrl.x_en = 1'b1; ctrl.x_sel = X_SEL_A; reads_a = 1'b1;
          end else if (opcode[7:3] == 5'b10000) begin
            illegal = 1'b0; ctrl.a_en = 1'b1; ctrl.a_sel = A_SEL_X; reads_x = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/decode_compute1_stage1.sv
// BPF pipeline stage 1: decode, A/X hazard stall, jump squash and RET halt.
module decode_compute1_stage1
  import decode_compute1_stage1_pkg::*;
#(
  parameter int unsigned IMM_W = 32,
  parameter int unsigned OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      instr_in,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             s2_A_en,
  input  logic             s2_X_en,
  input  logic             s2_PC_en,
  input  logic             restart,
  output logic [3:0]       ALU_sel,
  output logic [2:0]       jmp_type,
  output logic             PC_en,
  output logic [OFF_W-1:0] jt_out,
  output logic [OFF_W-1:0] jf_out,
  output logic [IMM_W-1:0] imm_out,
  output logic             packet_mem_rd_en,
  output logic [1:0]       transfer_sz,
  output logic             regfile_sel,
  output logic             regfile_wr_en,
  output logic [2:0]       A_sel,
  output logic             A_en,
  output logic [1:0]       X_sel,
  output logic             X_en,
  output logic             ret_valid,
  output logic             ret_sel,
  output logic             halted
);

  ctrl_t  ctrl;
  ctrl_t  issued;
  logic   reads_a, reads_x, is_jmp, is_ret, illegal;
  logic   hazard, issue;
  state_e state, state_nxt;

  bpf_decode u_decode (
    .opcode  (instr_in[63:48]),
    .ctrl    (ctrl),
    .reads_a (reads_a),
    .reads_x (reads_x),
    .is_jmp  (is_jmp),
    .is_ret  (is_ret),
    .illegal (illegal)
  );

  // Own A_en/X_en cover the instruction now in stage2's input; s2_* cover the one leaving it.
  assign hazard = (reads_a & (A_en | s2_A_en)) | (reads_x & (X_en | s2_X_en));

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    issue       = 1'b0;
    case (state)
      ST_RUN: begin
        instr_ready = ~hazard;
        issue       = instr_valid & ~hazard & ~illegal;
        if (issue && is_jmp)      state_nxt = ST_JWAIT;
        else if (issue && is_ret) state_nxt = ST_HALT;
      end
      ST_JWAIT: begin
        instr_ready = 1'b1;
        if (s2_PC_en) state_nxt = ST_RUN;
      end
      ST_HALT: if (restart) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
    issued = issue ? ctrl : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= ST_RUN;
      halted           <= 1'b0;
      ALU_sel          <= '0;
      jmp_type         <= '0;
      PC_en            <= 1'b0;
      packet_mem_rd_en <= 1'b0;
      transfer_sz      <= '0;
      regfile_sel      <= 1'b0;
      regfile_wr_en    <= 1'b0;
      A_en             <= 1'b0;
      X_en             <= 1'b0;
      ret_valid        <= 1'b0;
      A_sel            <= '0;
      X_sel            <= '0;
      ret_sel          <= 1'b0;
      imm_out          <= '0;
      jt_out           <= '0;
      jf_out           <= '0;
    end else begin
      state            <= state_nxt;
      halted           <= (state_nxt == ST_HALT);
      ALU_sel          <= issued.alu_sel;
      jmp_type         <= issued.jmp_type;
      PC_en            <= issued.pc_en;
      packet_mem_rd_en <= issued.pkt_rd;
      transfer_sz      <= issued.xfer_sz;
      regfile_sel      <= issued.rf_sel;
      regfile_wr_en    <= issued.rf_wr;
      A_en             <= issued.a_en;
      X_en             <= issued.x_en;
      ret_valid        <= issued.ret_valid;
      // Data fields only move on an issued instruction; bubbles leave them stale.
      if (issue) begin
        A_sel   <= ctrl.a_sel;
        X_sel   <= ctrl.x_sel;
        ret_sel <= ctrl.ret_sel;
        imm_out <= IMM_W'(instr_in[31:0]);
        jt_out  <= OFF_W'(instr_in[47:40]);
        jf_out  <= OFF_W'(instr_in[39:32]);
      end
    end
  end

endmodule

// File: tb/tb_decode_compute1_stage1.sv
// Randomized bench for decode_compute1_stage1 against an opcode-value reference model.
module tb_decode_compute1_stage1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] instr_in = '0;
  logic        instr_valid = 1'b0, instr_ready;
  logic        s2_A_en = 1'b0, s2_X_en = 1'b0, s2_PC_en = 1'b0, restart = 1'b0;
  logic [3:0]  ALU_sel;
  logic [2:0]  jmp_type, A_sel;
  logic        PC_en, packet_mem_rd_en, regfile_sel, regfile_wr_en;
  logic [7:0]  jt_out, jf_out;
  logic [31:0] imm_out;
  logic [1:0]  transfer_sz, X_sel;
  logic        A_en, X_en, ret_valid, ret_sel, halted;

  decode_compute1_stage1 #(.IMM_W(32), .OFF_W(8)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .s2_A_en(s2_A_en), .s2_X_en(s2_X_en),
    .s2_PC_en(s2_PC_en), .restart(restart), .ALU_sel(ALU_sel), .jmp_type(jmp_type),
    .PC_en(PC_en), .jt_out(jt_out), .jf_out(jf_out), .imm_out(imm_out),
    .packet_mem_rd_en(packet_mem_rd_en), .transfer_sz(transfer_sz),
    .regfile_sel(regfile_sel), .regfile_wr_en(regfile_wr_en), .A_sel(A_sel),
    .A_en(A_en), .X_sel(X_sel), .X_en(X_en), .ret_valid(ret_valid),
    .ret_sel(ret_sel), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic legal, ra, rx, jmp, ret;
    logic [3:0] alu; logic [2:0] jmpt; logic pc, rd; logic [1:0] sz; logic rsel, wr;
    logic [2:0] asel; logic aen; logic [1:0] xsel; logic xen, rv, rs;
  } ref_t;

  typedef struct packed {
    logic [3:0] alu; logic [2:0] jmpt; logic pc, rd; logic [1:0] sz; logic rsel, wr;
    logic [2:0] asel; logic aen; logic [1:0] xsel; logic xen, rv, rs, halted;
    logic [31:0] imm; logic [7:0] jto, jfo;
  } exp_t;

  int unsigned n_errors = 0, n_checks = 0;
  exp_t        mo;
  int unsigned m_state;        // 0 RUN, 1 JWAIT, 2 HALT
  logic        s2a_q, s2x_q, data_valid, last_ready;
  logic [15:0] ops[$] = '{16'h00, 16'h20, 16'h28, 16'h30, 16'h40, 16'h48, 16'h50, 16'h60,
    16'h80, 16'h01, 16'h61, 16'hB1, 16'h02, 16'h03, 16'h04, 16'h0C, 16'h14, 16'h1C,
    16'h2C, 16'h3C, 16'h4C, 16'h5C, 16'h6C, 16'h7C, 16'h84, 16'h94, 16'h9C, 16'hA4,
    16'hAC, 16'h05, 16'h15, 16'h1D, 16'h25, 16'h2D, 16'h35, 16'h3D, 16'h45, 16'h4D,
    16'h06, 16'h16, 16'h07, 16'h87};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Reference decode from the BPF rules, working on the numeric opcode value.
  function automatic ref_t ref_decode(input logic [15:0] code);
    ref_t r;
    int unsigned c, cls, sz, md, op, src;
    r = '0;
    if (code > 16'h00FF) return r;
    c = code; cls = c % 8; sz = (c / 8) % 4; md = c / 32; op = c / 16; src = (c / 8) % 2;
    case (cls)
      0: if (((md == 1 || md == 2) && sz < 3) || (sz == 0 && (md == 0 || md == 3 || md == 4))) begin
        r.legal = 1; r.aen = 1;
        if (md == 1 || md == 2) begin r.asel = 1; r.rd = 1; r.sz = 2'(sz); r.rx = (md == 2); end
        else if (md == 3) r.asel = 4;
        else if (md == 4) r.asel = 5;
      end
      1: if (c == 'h01 || c == 'h61 || c == 'hB1) begin
        r.legal = 1; r.xen = 1;
        if (c == 'h61) r.xsel = 3;
        if (c == 'hB1) begin r.xsel = 1; r.rd = 1; r.sz = 2; end
      end
      2, 3: if (c == cls) begin r.legal = 1; r.rsel = 1; r.wr = 1; r.ra = (c == 2); r.rx = (c == 3); end
      4: if (op <= 10 && !(op == 8 && src == 1)) begin
        r.legal = 1; r.alu = 4'(op); r.asel = 2; r.aen = 1; r.ra = 1; r.rx = src[0];
      end
      5: if (op <= 4 && !(op == 0 && src == 1)) begin
        r.legal = 1; r.jmp = 1; r.pc = 1; r.jmpt = 3'(op); r.ra = 1; r.rx = src[0];
      end
      6: if (c == 'h06 || c == 'h16) begin
        r.legal = 1; r.ret = 1; r.rv = 1; r.rs = (c == 'h16); r.ra = (c == 'h16);
      end
      default: if (c == 'h07 || c == 'h87) begin
        r.legal = 1;
        if (c == 'h07) begin r.ra = 1; r.xen = 1; r.xsel = 2; end
        else begin r.rx = 1; r.aen = 1; r.asel = 3; end
      end
    endcase
    return r;
  endfunction

  function automatic logic [63:0] mk(input logic [15:0] op, input logic [7:0] jt,
                                     input logic [7:0] jf, input logic [31:0] k);
    return {op, jt, jf, k};
  endfunction

  task automatic check_outputs(input logic with_data);
    check("ALU_sel", ALU_sel, mo.alu);
    check("jmp_type", jmp_type, mo.jmpt);
    check("PC_en", PC_en, mo.pc);
    check("packet_mem_rd_en", packet_mem_rd_en, mo.rd);
    check("transfer_sz", transfer_sz, mo.sz);
    check("regfile_sel", regfile_sel, mo.rsel);
    check("regfile_wr_en", regfile_wr_en, mo.wr);
    check("A_en", A_en, mo.aen);
    check("X_en", X_en, mo.xen);
    check("ret_valid", ret_valid, mo.rv);
    check("halted", halted, mo.halted);
    if (with_data) begin
      check("A_sel", A_sel, mo.asel);
      check("X_sel", X_sel, mo.xsel);
      check("ret_sel", ret_sel, mo.rs);
      check("imm_out", imm_out, mo.imm);
      check("jt_out", jt_out, mo.jto);
      check("jf_out", jf_out, mo.jfo);
    end
  endtask

  // One clock: drive at negedge, check ready, predict, check registered outputs after posedge.
  task automatic step(input logic v, input logic [63:0] ins, input logic xa, input logic xx,
                      input logic pc, input logic rs_in);
    ref_t d;
    logic hz, rdy, iss;
    int unsigned nxt;
    instr_valid = v; instr_in = ins; s2_A_en = s2a_q | xa; s2_X_en = s2x_q | xx;
    s2_PC_en = pc; restart = rs_in;
    d = ref_decode(ins[63:48]);
    hz = (d.ra & (mo.aen | s2_A_en)) | (d.rx & (mo.xen | s2_X_en));
    rdy = (m_state == 0) ? ~hz : (m_state == 1);
    #1;
    last_ready = instr_ready;
    check("instr_ready", instr_ready, rdy);
    iss = v & rdy & (m_state == 0) & d.legal;
    s2a_q = mo.aen; s2x_q = mo.xen;
    nxt = m_state;
    if (m_state == 0 && iss && d.jmp) nxt = 1;
    else if (m_state == 0 && iss && d.ret) nxt = 2;
    else if (m_state == 1 && pc) nxt = 0;
    else if (m_state == 2 && rs_in) nxt = 0;
    {mo.alu, mo.jmpt, mo.pc, mo.rd, mo.sz, mo.rsel, mo.wr, mo.aen, mo.xen, mo.rv} = '0;
    if (iss) begin
      mo.alu = d.alu; mo.jmpt = d.jmpt; mo.pc = d.pc; mo.rd = d.rd; mo.sz = d.sz;
      mo.rsel = d.rsel; mo.wr = d.wr; mo.aen = d.aen; mo.xen = d.xen; mo.rv = d.rv;
      mo.asel = d.asel; mo.xsel = d.xsel; mo.rs = d.rs;
      mo.imm = ins[31:0]; mo.jto = ins[47:40]; mo.jfo = ins[39:32];
    end
    data_valid = iss;
    mo.halted = (nxt == 2);
    m_state = nxt;
    @(posedge clk); #1;
    check_outputs(data_valid);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; instr_valid = 1'b0; s2_A_en = 1'b0; s2_X_en = 1'b0;
    s2_PC_en = 1'b0; restart = 1'b0; instr_in = '0;
    mo = '0; m_state = 0; s2a_q = 1'b0; s2x_q = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs(1'b1);
    rst = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // Enter JWAIT, then reset from there.
    step(1, mk(16'h0015, 8'd2, 8'd0, 32'd7), 0, 0, 0, 0);
    do_reset();
    check("reset_halted", halted, 1'b0);

    step(1, mk(16'h0000, 8'd0, 8'd0, 32'd5), 0, 0, 0, 0);
    check("ld_imm_A_en", A_en, 1'b1);
    check("ld_imm_A_sel", A_sel, 3'd0);
    check("ld_imm_imm", imm_out, 32'd5);
    check("ld_imm_PC_en", PC_en, 1'b0);

    step(1, mk(16'h000C, 8'd0, 8'd0, 32'd0), 0, 0, 0, 0);
    check("addx_stall1", last_ready, 1'b0);
    step(1, mk(16'h000C, 8'd0, 8'd0, 32'd0), 0, 0, 0, 0);
    check("addx_stall2", last_ready, 1'b0);
    check("addx_bubble", A_en, 1'b0);
    step(1, mk(16'h000C, 8'd0, 8'd0, 32'd0), 0, 0, 0, 0);
    check("addx_A_sel", A_sel, 3'd2);
    check("addx_A_en", A_en, 1'b1);
    check("addx_ALU_sel", ALU_sel, 4'd0);

    step(0, '0, 0, 0, 0, 0);
    step(0, '0, 0, 0, 0, 0);
    step(1, mk(16'h0015, 8'd2, 8'd0, 32'd7), 0, 0, 0, 0);
    check("jeq_PC_en", PC_en, 1'b1);
    check("jeq_type", jmp_type, 3'd1);
    check("jeq_jt", jt_out, 8'd2);
    for (int i = 0; i < 3; i++) begin
      step(1, mk(16'h0000, 8'd0, 8'd0, 32'd1), 0, 0, 0, 0);
      check("jwait_drop", A_en, 1'b0);
    end
    step(1, mk(16'h0000, 8'd0, 8'd0, 32'd1), 0, 0, 1, 0);
    check("jwait_resolve_drop", A_en, 1'b0);
    step(1, mk(16'h0000, 8'd0, 8'd0, 32'd9), 0, 0, 0, 0);
    check("post_jmp_A_en", A_en, 1'b1);
    check("post_jmp_imm", imm_out, 32'd9);

    step(1, mk(16'h0020, 8'd0, 8'd0, 32'd14), 0, 0, 0, 0);
    check("ldw_rd", packet_mem_rd_en, 1'b1);
    check("ldw_sz", transfer_sz, 2'b00);
    check("ldw_A_sel", A_sel, 3'd1);
    check("ldw_imm", imm_out, 32'd14);
    step(1, mk(16'h0030, 8'd0, 8'd0, 32'd3), 0, 0, 0, 0);
    check("ldb_sz", transfer_sz, 2'b10);

    step(1, mk(16'h00FF, 8'd0, 8'd0, 32'd3), 0, 0, 0, 0);
    check("illegal_bubble", A_en | X_en | PC_en | ret_valid, 1'b0);

    step(1, mk(16'h0006, 8'd0, 8'd0, 32'hFFFF), 0, 0, 0, 0);
    check("ret_valid", ret_valid, 1'b1);
    check("ret_sel", ret_sel, 1'b0);
    check("ret_halted", halted, 1'b1);
    step(1, mk(16'h0000, 8'd0, 8'd0, 32'd1), 0, 0, 0, 0);
    check("halt_ready", last_ready, 1'b0);
    check("ret_pulse_end", ret_valid, 1'b0);
    step(0, '0, 0, 0, 0, 1);
    check("restart_halted", halted, 1'b0);
    step(1, mk(16'h0000, 8'd0, 8'd0, 32'd2), 0, 0, 0, 0);
    check("restart_ready", last_ready, 1'b1);

    for (int n = 0; n < 2000; n++) begin
      logic [15:0] op;
      if ($urandom_range(99) < 85) op = ops[$urandom_range(ops.size() - 1)];
      else if ($urandom_range(3) == 0) op = 16'($urandom);
      else op = 16'($urandom_range(255));
      step($urandom_range(9) < 8, mk(op, 8'($urandom), 8'($urandom), $urandom),
           $urandom_range(9) == 0, $urandom_range(9) == 0,
           $urandom_range(3) == 0, $urandom_range(6) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
